// File: rtl/tree_cfg_sequencer_pkg.sv
// Shared tree-NoC definitions: geometry helpers, default derived constants,
// the config-bus payload type and the sequencer state encoding.
package tree_cfg_sequencer_pkg;

    // base**e for small non-negative integers
    function automatic int powi(input int base, input int e);
        int r;
        r = 1;
        for (int i = 0; i < e; i++) r = r * base;
        return r;
    endfunction

    // sum of base**i for i = 0 .. n-1 (router count of an n-layer tree)
    function automatic int sum_powi(input int base, input int n);
        int s;
        s = 0;
        for (int i = 0; i < n; i++) s = s + powi(base, i);
        return s;
    endfunction

    // ceil(log2(v)), never below 1 so every field keeps at least one bit
    function automatic int log2(input int v);
        int w;
        w = 0;
        while ((1 << w) < v) w = w + 1;
        return (w < 1) ? 1 : w;
    endfunction

    localparam int TREE_K   = 2;
    localparam int TREE_L   = 3;
    localparam int TREE_KW  = log2(TREE_K);
    localparam int TREE_LW  = log2(TREE_L);
    localparam int TREE_LKW = TREE_L * TREE_KW;
    localparam int TREE_NR  = sum_powi(TREE_K, TREE_L);
    localparam int TREE_NRW = log2(TREE_NR);

    // One config write as seen by a router-side receiver
    typedef struct packed {
        logic [TREE_NRW-1:0]          rid;
        logic [TREE_LW+TREE_LKW-1:0]  addr;
        logic                         last;
    } tree_cfg_bus_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } cfg_seq_state_e;

endpackage

// File: rtl/tree_cfg_sequencer_digit_counter.sv
// L-digit base-K position counter. The increment enters at a selectable
// digit so that each tree level steps by K^(L-1-level) in position space.
module tree_addr_digit_counter #(
    parameter int K  = 2,
    parameter int L  = 3,
    parameter int Kw = 1,
    parameter int Lw = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              inc_i,
    input  logic [Lw-1:0]     start_idx_i,
    output logic [L*Kw-1:0]   digits_o,
    output logic              carry_o
);

    logic [L*Kw-1:0] digits_q, digits_d, digits_inc;
    logic            carry;

    // Ripple a +1 upward from start_idx_i; digits wrap at K-1, not 2^Kw-1
    always_comb begin
        digits_inc = digits_q;
        carry      = 1'b1;
        carry_o    = 1'b0;
        for (int i = 0; i < L; i++) begin
            if ((i >= int'(start_idx_i)) && carry) begin
                if (digits_q[i*Kw +: Kw] == Kw'(K - 1)) begin
                    digits_inc[i*Kw +: Kw] = '0;
                end else begin
                    digits_inc[i*Kw +: Kw] = digits_q[i*Kw +: Kw] + Kw'(1);
                    carry = 1'b0;
                end
            end
            if (i == L - 2) carry_o = carry;
        end
        if (clr_i)      digits_d = '0;
        else if (inc_i) digits_d = digits_inc;
        else            digits_d = digits_q;
    end

    // Digit register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) digits_q <= '0;
        else       digits_q <= digits_d;
    end

    assign digits_o = digits_q;

endmodule

// File: rtl/tree_cfg_sequencer.sv
// Boot-time tree configuration sequencer: walks routers root-first,
// level by level, and issues one {rid, {layer, pos}} write per router.
module tree_cfg_sequencer
    import tree_cfg_sequencer_pkg::*;
#(
    parameter int K = TREE_K,
    parameter int L = TREE_L
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic                              cfg_valid,
    input  logic                              cfg_ready,
    output logic [log2(sum_powi(K, L))-1:0]   cfg_rid,
    output logic [log2(L)+L*log2(K)-1:0]      cfg_addr,
    output logic                              cfg_last
);

    localparam int Kw  = log2(K);
    localparam int Lw  = log2(L);
    localparam int LKw = L * Kw;
    localparam int NR  = sum_powi(K, L);
    localparam int NRw = log2(NR);

    cfg_seq_state_e   state_q, state_d;
    logic [NRw-1:0]   rid_q, rid_d;
    logic [Lw-1:0]    level_q, level_d;
    logic [Lw-1:0]    layer;
    logic [LKw-1:0]   digits;
    logic             carry;
    logic             ctr_clr, ctr_inc;
    logic             is_last, lvl_done;

    // Layer doubles as the digit index where this level's increment enters
    assign layer    = Lw'(L - 1) - level_q;
    assign is_last  = (rid_q == NRw'(NR - 1));
    assign lvl_done = (level_q == '0) || carry;

    tree_addr_digit_counter #(
        .K  (K),
        .L  (L),
        .Kw (Kw),
        .Lw (Lw)
    ) u_digits (
        .clk         (clk),
        .reset       (reset),
        .clr_i       (ctr_clr),
        .inc_i       (ctr_inc),
        .start_idx_i (layer),
        .digits_o    (digits),
        .carry_o     (carry)
    );

    // Next-state, counter control and bus outputs
    always_comb begin
        state_d   = state_q;
        rid_d     = rid_q;
        level_d   = level_q;
        ctr_clr   = 1'b0;
        ctr_inc   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        cfg_valid = 1'b0;
        cfg_rid   = '0;
        cfg_addr  = '0;
        cfg_last  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rid_d   = '0;
                    level_d = '0;
                    ctr_clr = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                busy      = 1'b1;
                cfg_valid = 1'b1;
                cfg_rid   = rid_q;
                cfg_addr  = {layer, digits};
                cfg_last  = is_last;
                if (cfg_ready) begin
                    if (is_last) begin
                        state_d = ST_DONE;
                    end else begin
                        rid_d = rid_q + NRw'(1);
                        if (lvl_done) begin
                            level_d = level_q + Lw'(1);
                            ctr_clr = 1'b1;
                        end else begin
                            ctr_inc = 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and walk counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rid_q   <= '0;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            rid_q   <= rid_d;
            level_q <= level_d;
        end
    end

endmodule

// File: tb/tb_tree_cfg_sequencer.sv
// Bench for tree_cfg_sequencer: three geometries (K,L) = (2,3), (3,3), (4,2)
// compared against an arithmetic model of the router walk.
module tb_tree_cfg_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start_s [3];
    logic ready_s [3];
    logic busy_s  [3];
    logic done_s  [3];
    logic valid_s [3];
    logic last_s  [3];

    logic [2:0] rid0;  logic [4:0] addr0;
    logic [3:0] rid1;  logic [7:0] addr1;
    logic [2:0] rid2;  logic [4:0] addr2;

    int checks = 0;
    int errors = 0;
    int KP [3] = '{2, 3, 4};
    int LP [3] = '{3, 3, 2};

    tree_cfg_sequencer #(.K(2), .L(3)) u0 (
        .clk(clk), .reset(reset), .start(start_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .cfg_valid(valid_s[0]), .cfg_ready(ready_s[0]), .cfg_rid(rid0), .cfg_addr(addr0),
        .cfg_last(last_s[0]));

    tree_cfg_sequencer #(.K(3), .L(3)) u1 (
        .clk(clk), .reset(reset), .start(start_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .cfg_valid(valid_s[1]), .cfg_ready(ready_s[1]), .cfg_rid(rid1), .cfg_addr(addr1),
        .cfg_last(last_s[1]));

    tree_cfg_sequencer #(.K(4), .L(2)) u2 (
        .clk(clk), .reset(reset), .start(start_s[2]), .busy(busy_s[2]), .done(done_s[2]),
        .cfg_valid(valid_s[2]), .cfg_ready(ready_s[2]), .cfg_rid(rid2), .cfg_addr(addr2),
        .cfg_last(last_s[2]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sample(input int n, output int v, output int b, output int d,
                          output int r, output int a, output int l);
        v = int'(valid_s[n]);
        b = int'(busy_s[n]);
        d = int'(done_s[n]);
        l = int'(last_s[n]);
        case (n)
            0:       begin r = int'(rid0); a = int'(addr0); end
            1:       begin r = int'(rid1); a = int'(addr1); end
            default: begin r = int'(rid2); a = int'(addr2); end
        endcase
    endtask

    function automatic int nr_of(input int n);
        int s, pw;
        s = 0; pw = 1;
        for (int i = 0; i < LP[n]; i++) begin s += pw; pw *= KP[n]; end
        return s;
    endfunction

    // Router r: find its level and position, scale position into the
    // leaf-relative address space and pack it as base-K digits.
    function automatic void model(input int n, input int r, output int a, output int last);
        int k, lyr, kw, lv, base, cnt, v, packed_pos;
        k = KP[n]; lyr = LP[n];
        kw = (k <= 2) ? 1 : $clog2(k);
        lv = 0; base = 0; cnt = 1;
        while (r >= base + cnt) begin base += cnt; cnt *= k; lv++; end
        v = r - base;
        for (int i = 0; i < lyr - 1 - lv; i++) v *= k;
        packed_pos = 0;
        for (int i = 0; i < lyr; i++) begin
            packed_pos |= (v % k) << (i * kw);
            v /= k;
        end
        a = ((lyr - 1 - lv) << (lyr * kw)) | packed_pos;
        last = (r == nr_of(n) - 1) ? 1 : 0;
    endfunction

    // Called at a negedge in IDLE; returns at a negedge in IDLE.
    task automatic run_pass(input int n, input bit rnd, input int restart_at, input bit b2b);
        int idx, cyc, v, b, d, r, a, l, ea, el, nr;
        bit rdy;
        nr = nr_of(n); idx = 0; cyc = 0;
        start_s[n] = 1'b1;
        @(negedge clk);
        start_s[n] = 1'b0;
        while (idx < nr && cyc < 400) begin
            sample(n, v, b, d, r, a, l);
            model(n, idx, ea, el);
            check("valid", v, 1);
            check("busy", b, 1);
            check("done_early", d, 0);
            check("rid", r, idx);
            check("addr", a, ea);
            check("last", l, el);
            if (n == 1) check("digit0_range", ((a & 3) == 3) ? 1 : 0, 0);
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start_s[n] = (idx == restart_at);
            ready_s[n] = rdy;
            if (rdy) idx++;
            cyc++;
            @(negedge clk);
        end
        check("pass_len", idx, nr);
        if (!rnd) check("throughput", cyc, nr);
        sample(n, v, b, d, r, a, l);
        check("done_pulse", d, 1);
        check("busy_in_done", b, 0);
        check("valid_in_done", v, 0);
        check("last_in_done", l, 0);
        start_s[n] = b2b;
        @(negedge clk);
        start_s[n] = 1'b0;
        sample(n, v, b, d, r, a, l);
        check("done_once", d, 0);
        check("valid_idle", v, 0);
        check("busy_idle", b, 0);
    endtask

    initial begin
        int v, b, d, r, a, l;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin start_s[i] = 1'b0; ready_s[i] = 1'b0; end
        #2;
        for (int i = 0; i < 3; i++) begin
            sample(i, v, b, d, r, a, l);
            check("rst_valid", v, 0);
            check("rst_busy", b, 0);
            check("rst_done", d, 0);
            check("rst_rid", r, 0);
            check("rst_addr", a, 0);
            check("rst_last", l, 0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_pass(0, 1'b0, -1, 1'b0);
        run_pass(1, 1'b0, -1, 1'b0);
        run_pass(2, 1'b1, -1, 1'b0);
        run_pass(2, 1'b1, -1, 1'b0);
        run_pass(0, 1'b1, 3, 1'b0);
        run_pass(1, 1'b1, 5, 1'b1);
        run_pass(1, 1'b0, -1, 1'b0);

        // asynchronous reset in the middle of a pass
        start_s[0] = 1'b1; ready_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (4) @(negedge clk);
        sample(0, v, b, d, r, a, l);
        check("pre_reset_rid", r, 4);
        check("pre_reset_valid", v, 1);
        #2 reset = 1'b1;
        #1;
        sample(0, v, b, d, r, a, l);
        check("async_valid", v, 0);
        check("async_busy", b, 0);
        check("async_rid", r, 0);
        check("async_addr", a, 0);
        #1 reset = 1'b0;
        @(negedge clk);
        sample(0, v, b, d, r, a, l);
        check("post_reset_idle", v, 0);
        run_pass(0, 1'b0, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
